// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch stage front end. Owns the architectural PC, issues single-outstanding
// instruction-memory reads, and loads the IF/ID pipeline register. A redirect
// from the next-PC logic in EX reloads the PC, flushes IF/ID and kills any
// fetch already accepted by memory. Hazard-unit stalls are absorbed by a
// one-entry hold buffer so a returning response is never lost.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            synchronous active-high reset
//   redirect_valid single-cycle jump strobe from next-PC logic
//   redirect_pc    redirect target (bits [1:0] forced to zero)
//   stall          hazard-unit hold of IF/ID
//   imem_req       read request (REQ state only)
//   imem_addr      read address, always equal to the PC register
//   imem_gnt       request accepted this cycle
//   imem_rvalid    read data valid
//   imem_rdata     read data
//   if_pc          IF/ID PC
//   if_inst        IF/ID instruction
//   if_valid       IF/ID holds a real instruction
//   if_flush       one-cycle pulse after IF/ID was squashed by a redirect
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        kill_reg;
  logic [31:0] hold_inst_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] if_inst_reg;
  logic        if_valid_reg;
  logic        if_flush_reg;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        load_fetch;
  logic        load_hold;

  // Word-align the target; masking (rather than slicing) keeps every bit used.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  // Natural 32-bit overflow gives the required wrap to zero.
  assign pc_plus4        = pc_reg + 32'd4;

  // A fresh response goes straight to IF/ID when not stalled; a parked one
  // leaves the hold buffer as soon as the stall drops.
  assign load_fetch = (state_reg == S_WAIT) && imem_rvalid && !kill_reg && !stall;
  assign load_hold  = (state_reg == S_HOLD) && !stall;

  // The request is combinational from state so it drops in the reset cycle.
  assign imem_req  = (state_reg == S_REQ) && !rst;
  assign imem_addr = pc_reg;

  assign if_pc    = if_pc_reg;
  assign if_inst  = if_inst_reg;
  assign if_valid = if_valid_reg;
  assign if_flush = if_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      kill_reg      <= 1'b0;
      hold_inst_reg <= NOP_INST;
      if_pc_reg     <= RESET_PC;
      if_inst_reg   <= NOP_INST;
      if_valid_reg  <= 1'b0;
      if_flush_reg  <= 1'b0;
    end else begin
      if_flush_reg <= redirect_valid;

      if (redirect_valid) begin
        // Redirect beats both stall and a same-cycle response.
        pc_reg       <= redirect_target;
        if_valid_reg <= 1'b0;
        if_inst_reg  <= NOP_INST;
        case (state_reg)
          S_REQ: begin
            // Old address already accepted: its response must be dropped.
            if (imem_gnt) begin
              kill_reg  <= 1'b1;
              state_reg <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              // The response arriving now is the one being dropped, so any
              // earlier kill is also satisfied by it.
              kill_reg  <= 1'b0;
              state_reg <= S_REQ;
            end else begin
              kill_reg  <= 1'b1;
            end
          end
          default: begin
            // HOLD: parked instruction is wrong-path, discard it.
            state_reg <= S_REQ;
          end
        endcase
      end else begin
        case (state_reg)
          S_REQ: begin
            if (imem_gnt) begin
              state_reg <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (kill_reg) begin
                kill_reg  <= 1'b0;
                state_reg <= S_REQ;
              end else if (stall) begin
                hold_inst_reg <= imem_rdata;
                state_reg     <= S_HOLD;
              end else begin
                state_reg <= S_REQ;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              state_reg <= S_REQ;
            end
          end
          default: begin
            state_reg <= S_REQ;
          end
        endcase

        // The PC only advances once its instruction has entered IF/ID, so
        // the PC register doubles as the PC of the outstanding/parked fetch.
        if (load_fetch || load_hold) begin
          if_pc_reg    <= pc_reg;
          if_inst_reg  <= load_fetch ? imem_rdata : hold_inst_reg;
          if_valid_reg <= 1'b1;
          pc_reg       <= pc_plus4;
        end else if (!stall) begin
          // Nothing delivered and downstream is moving: insert a bubble.
          if_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Drives fetch_pc_unit with directed scenarios followed by randomized
// redirect/stall/grant/latency traffic. A transaction-level model of the
// fetch stage (outstanding fetch, pending drop, parked instruction) predicts
// every output each cycle. A second instance with RESET_PC at the top of the
// address space exercises PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_flush;

  // Wrap-around DUT signals
  logic        w_rst;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;
  logic        w_if_valid;
  logic        w_if_flush;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_flush(if_flush)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_pc(w_if_pc), .if_inst(w_if_inst), .if_valid(w_if_valid), .if_flush(w_if_flush)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc          = 32'h0;
  bit          m_pending     = 1'b0;  // a granted fetch awaits its response
  bit          m_discard     = 1'b0;  // that response belongs to a dead path
  bit          m_parked      = 1'b0;  // an instruction waits for stall release
  logic [31:0] m_parked_inst = 32'h0;
  logic [31:0] m_if_pc       = 32'h0;
  logic [31:0] m_if_inst     = NOP;
  bit          m_if_valid    = 1'b0;
  bit          m_if_flush    = 1'b0;

  task automatic deliver(input logic [31:0] inst);
    m_if_pc    = m_pc;
    m_if_inst  = inst;
    m_if_valid = 1'b1;
    m_pc       = m_pc + 32'd4;
  endtask

  task automatic model_update();
    bit idle;
    bit loaded;
    if (rst) begin
      m_pc = 32'h0; m_pending = 0; m_discard = 0; m_parked = 0;
      m_if_pc = 32'h0; m_if_inst = NOP; m_if_valid = 0; m_if_flush = 0;
    end else begin
      idle   = !m_pending && !m_parked;
      loaded = 0;
      if (redirect_valid) begin
        if (idle) begin
          if (imem_gnt) begin m_pending = 1; m_discard = 1; end
        end else if (m_pending) begin
          if (imem_rvalid) begin m_pending = 0; m_discard = 0; end
          else m_discard = 1;
        end else begin
          m_parked = 0;
        end
        m_pc       = {redirect_pc[31:2], 2'b00};
        m_if_valid = 0;
        m_if_inst  = NOP;
      end else begin
        if (idle) begin
          if (imem_gnt) m_pending = 1;
        end else if (m_pending) begin
          if (imem_rvalid) begin
            m_pending = 0;
            if (m_discard) m_discard = 0;
            else if (!stall) begin deliver(imem_rdata); loaded = 1; end
            else begin m_parked = 1; m_parked_inst = imem_rdata; end
          end
        end else if (!stall) begin
          deliver(m_parked_inst);
          m_parked = 0;
          loaded = 1;
        end
        if (!loaded && !stall) m_if_valid = 0;
      end
      m_if_flush = redirect_valid;
    end
  endtask

  // ---------------- memory environment + per-cycle compare ----------------
  bit          k_rst = 1, k_rv = 0, k_st = 0, k_gnt = 0, k_stray = 0;
  logic [31:0] k_tgt = 32'h0;
  int          k_lat = 0;
  bit          mem_busy = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_lat = 0;

  task automatic cycle();
    bit          exp_req;
    bit          s_req;
    logic [31:0] s_addr;
    bit          resp;
    rst            = k_rst;
    redirect_valid = k_rv;
    redirect_pc    = k_tgt;
    stall          = k_st;
    imem_gnt       = k_gnt;
    resp           = mem_busy && (mem_lat == 0);
    if (resp) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hA0 + mem_addr;
    end else begin
      imem_rvalid = k_stray; imem_rdata = $urandom;
    end
    #1;
    exp_req = !k_rst && !m_pending && !m_parked;
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("if_pc", if_pc, m_if_pc);
    check("if_inst", if_inst, m_if_inst);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
    check("if_flush", {31'b0, if_flush}, {31'b0, m_if_flush});
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    model_update();
    if (k_rst) begin
      mem_busy = 0;
    end else begin
      if (resp) mem_busy = 0;
      else if (mem_busy && mem_lat > 0) mem_lat--;
      if (s_req && imem_gnt) begin
        mem_busy = 1; mem_addr = s_addr; mem_lat = k_lat;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; stall = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    w_rst = 1; w_gnt = 0; w_rvalid = 0; w_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // ---- wrap-around instance ----
    #1;
    check("w_req_in_reset", {31'b0, w_req}, 32'h0);
    check("w_if_pc_reset", w_if_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rst = 0; w_gnt = 1;
    #1;
    check("w_req", {31'b0, w_req}, 32'h1);
    check("w_addr_top", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_gnt = 0; w_rvalid = 1; w_rdata = 32'h1234_5678;
    #1;
    check("w_req_wait", {31'b0, w_req}, 32'h0);
    @(negedge clk);
    w_rvalid = 0;
    #1;
    check("w_addr_wrap", w_addr, 32'h0000_0000);
    check("w_if_pc", w_if_pc, 32'hFFFF_FFFC);
    check("w_if_inst", w_if_inst, 32'h1234_5678);
    check("w_if_valid", {31'b0, w_if_valid}, 32'h1);
    @(negedge clk);

    // ---- 1: reset then back-to-back fetches ----
    k_rst = 1; cycle(); cycle();
    check("t1_reset_if_pc", if_pc, 32'h0);
    check("t1_reset_if_inst", if_inst, NOP);
    k_rst = 0; k_gnt = 1; k_lat = 0;
    cycle(); cycle();
    check("t1_if_pc0", if_pc, 32'h0);
    check("t1_if_inst0", if_inst, 32'hA0);
    check("t1_if_valid0", {31'b0, if_valid}, 32'h1);
    cycle(); cycle();
    check("t1_if_pc4", if_pc, 32'h4);
    check("t1_if_inst4", if_inst, 32'hA4);
    cycle();
    check("t1_bubble", {31'b0, if_valid}, 32'h0);

    // ---- 2: stall as response for addr 8 returns ----
    k_st = 1; cycle();
    check("t2_hold_if_pc", if_pc, 32'h4);
    check("t2_hold_if_inst", if_inst, 32'hA4);
    check("t2_hold_req", {31'b0, imem_req}, 32'h0);
    cycle(); cycle();
    k_st = 0; cycle();
    check("t2_rel_if_pc", if_pc, 32'h8);
    check("t2_rel_if_inst", if_inst, 32'hA8);
    check("t2_rel_addr", imem_addr, 32'hC);

    // ---- 3: redirect in WAIT, response two cycles later ----
    k_lat = 2; cycle();
    k_rv = 1; k_tgt = 32'h0000_0103; cycle();
    check("t3_flush", {31'b0, if_flush}, 32'h1);
    check("t3_if_inst", if_inst, NOP);
    check("t3_if_valid", {31'b0, if_valid}, 32'h0);
    k_rv = 0; cycle();
    check("t3_flush_end", {31'b0, if_flush}, 32'h0);
    cycle();
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_new_req", {31'b0, imem_req}, 32'h1);
    k_lat = 0;

    // ---- 4: redirect coincident with grant ----
    k_rv = 1; k_tgt = 32'h200; cycle();
    k_rv = 0; cycle();
    check("t4_addr", imem_addr, 32'h200);
    check("t4_if_valid", {31'b0, if_valid}, 32'h0);

    // ---- 5: redirect + stall while in HOLD ----
    cycle();
    k_st = 1; cycle();
    k_rv = 1; k_tgt = 32'h300; cycle();
    check("t5_flush", {31'b0, if_flush}, 32'h1);
    check("t5_addr", imem_addr, 32'h300);
    check("t5_req", {31'b0, imem_req}, 32'h1);
    k_rv = 0; k_st = 0;

    // ---- 6: reset in WAIT, then stray rvalid ----
    cycle();
    k_rst = 1; cycle();
    check("t6_if_pc", if_pc, 32'h0);
    check("t6_if_inst", if_inst, NOP);
    k_rst = 0; k_gnt = 0; k_stray = 1; cycle();
    check("t6_stray_valid", {31'b0, if_valid}, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    k_stray = 0;

    // ---- random traffic ----
    for (int i = 0; i < 3000; i++) begin
      k_rst = ($urandom_range(0, 199) == 0);
      k_rv  = ($urandom_range(0, 9) == 0);
      k_tgt = $urandom;
      k_st  = ($urandom_range(0, 3) == 0);
      k_gnt = ($urandom_range(0, 1) == 1);
      k_lat = $urandom_range(0, 3);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side consumer of the next-PC redirect interface: owns the architectural PC register, issues instruction-memory reads, and loads the IF/ID pipeline register.
- Accepts a redirect (target + jump strobe) from the next-PC logic in EX. Kills wrong-path fetches and flushes IF/ID.
- Single outstanding request; honours hazard-unit stalls with a one-entry hold buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction placed in IF/ID on reset/flush (addi x0,x0,0).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
redirect_valid  input  1  jump strobe from next-PC logic; single-cycle
redirect_pc  input  32  redirect target; bits [1:0] forced to 0 on load
stall  input  1  hazard-unit hold of IF/ID
imem_req  output  1  read request
imem_addr  output  32  read address (= pc register)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
if_pc  output  32  IF/ID PC
if_inst  output  32  IF/ID instruction
if_valid  output  1  IF/ID holds a real instruction
if_flush  output  1  one-cycle pulse: IF/ID squashed by redirect

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=REQ, kill=0, hold buffer empty.
  - if_pc=RESET_PC, if_inst=NOP_INST, if_valid=0, if_flush=0.
  - imem_req=0 during the reset cycle.
  - Overrides every event, including mid-transaction. A late imem_rvalid arriving outside WAIT is ignored.
- States:
  - REQ: imem_req=1, imem_addr=pc. gnt=1 -> WAIT. imem_addr is stable while req=1 && gnt=0, except on redirect.
  - WAIT: imem_req=0, await imem_rvalid.
    - rvalid && kill: data dropped, kill<=0 -> REQ.
    - rvalid && !kill && !stall: if_inst<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 -> REQ.
    - rvalid && !kill && stall: rdata/pc captured in hold buffer -> HOLD.
  - HOLD: imem_req=0. When stall=0: load IF/ID from buffer (if_valid<=1), pc<=pc+4 -> REQ.
- IF/ID update:
  - stall=1 (no redirect): if_pc/if_inst/if_valid hold their values.
  - stall=0 and no instruction loaded this cycle: if_valid<=0 (bubble); if_pc/if_inst hold.
- Redirect (redirect_valid=1; priority over stall and over rvalid in the same cycle):
  - pc<={redirect_pc[31:2],2'b00}. IF/ID: if_valid<=0, if_inst<=NOP_INST. if_flush<=1 for exactly the next cycle.
  - REQ with gnt=0: stays REQ; new address is driven from the next cycle.
  - REQ with gnt=1: old address was accepted, so kill<=1 -> WAIT.
  - WAIT without rvalid: kill<=1, stays WAIT.
  - WAIT with rvalid: data dropped -> REQ.
  - HOLD: buffer discarded -> REQ.
  - A second redirect while kill=1 only updates pc; kill stays 1 and exactly one response is dropped.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Latency: minimum two cycles per instruction (REQ-grant, WAIT-rvalid). if_valid rises on the edge that samples rvalid.
- Redirect-to-new-request: imem_addr shows the target one cycle after redirect_valid, or after the killed response returns.

Test Plan:
1. Reset, gnt=1 every REQ cycle, rvalid 1 cycle later, rdata=32'hA0+addr -> if_pc sequence 0,4,8; if_valid pulses 1 every 2nd cycle; if_inst matches rdata.
2. Stall=1 asserted as rvalid returns for addr 8, held 3 cycles -> IF/ID keeps addr-4 instruction; state HOLD, imem_req=0; on release if_pc=8 and next imem_addr=12.
3. Redirect to 32'h0000_0103 in WAIT (no rvalid), response arrives 2 cycles later -> response dropped; if_flush=1 one cycle; if_inst=NOP_INST, if_valid=0; next imem_addr=32'h100.
4. Redirect to 32'h200 in the same cycle as gnt in REQ -> kill set; first rvalid discarded; then imem_addr=32'h200.
5. Redirect and stall together while in HOLD -> buffer discarded; if_flush pulses; imem_addr=target next cycle.
6. RESET_PC=32'hFFFF_FFFC -> after the first fetch, imem_addr=32'h0000_0000. Assert rst in WAIT -> outputs return to reset values; a stray rvalid the next cycle leaves if_valid=0.
